// File: rtl/riscv_pkg.sv
// Shared decode-path definitions: immediate format selects, skid-buffer
// state encoding and the datapath-width legality check.
package riscv_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_U   = 3'b011;
    localparam logic [2:0] IMM_J   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } buf_state_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Upstream/downstream valid-ready bundle of the immediate-generation stage.
// The stage uses the slave view; whoever feeds and drains it uses master.
interface imm_gen_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [2:0]      in_imm_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_target;
    logic            out_err;

    modport slave (
        input  in_valid, in_instr, in_pc, in_imm_sel, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_err
    );

    modport master (
        output in_valid, in_instr, in_pc, in_imm_sel, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_err
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate decode. Every format is first assembled as
// a 32-bit value whose bit 31 is the correct extension bit (zero for the
// zero-extended Z and SH formats), so one signed widening covers all cases.
module imm_extract
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_sel,
    output logic [XLEN-1:0] o_imm,
    output logic            o_err
);

    logic signed [31:0] w_imm32;

    // Assemble the selected format; the illegal select yields zero and err
    always_comb begin
        w_imm32 = '0;
        o_err   = 1'b0;
        case (i_sel)
            IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            IMM_Z:   w_imm32 = {27'b0, i_instr[19:15]};
            IMM_SH:  w_imm32 = (XLEN == 64) ? {26'b0, i_instr[25:20]}
                                            : {27'b0, i_instr[24:20]};
            default: o_err   = 1'b1;
        endcase
    end

    assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decode + target add ahead of a
// 2-entry (main + skid) buffer. in_ready and out_valid are flops, so there is
// no combinational path from out_ready back to in_ready.
module imm_gen_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_gen_stage_if.slave  bus
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_err;
    logic            w_in_xfer;
    logic            w_out_xfer;

    buf_state_e      r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_main_imm;
    logic [XLEN-1:0] r_main_tgt;
    logic            r_main_err;
    logic [XLEN-1:0] r_skid_imm;
    logic [XLEN-1:0] r_skid_tgt;
    logic            r_skid_err;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr (bus.in_instr),
        .i_sel   (bus.in_imm_sel),
        .o_imm   (w_imm),
        .o_err   (w_err)
    );

    // Target is finished before the buffer, so both entries hold final results
    assign w_target   = bus.in_pc + w_imm;
    assign w_in_xfer  = bus.in_valid & r_in_ready & ~flush;
    assign w_out_xfer = r_out_valid & bus.out_ready;

    // Skid-buffer FSM with registered handshake outputs; flush overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main_imm  <= '0;
            r_main_tgt  <= '0;
            r_main_err  <= 1'b0;
            r_skid_imm  <= '0;
            r_skid_tgt  <= '0;
            r_skid_err  <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main_imm  <= w_imm;
                        r_main_tgt  <= w_target;
                        r_main_err  <= w_err;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid_imm <= w_imm;
                        r_skid_tgt <= w_target;
                        r_skid_err <= w_err;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (w_in_xfer && w_out_xfer) begin
                        r_main_imm <= w_imm;
                        r_main_tgt <= w_target;
                        r_main_err <= w_err;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        r_main_imm <= r_skid_imm;
                        r_main_tgt <= r_skid_tgt;
                        r_main_err <= r_skid_err;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_imm    = r_main_imm;
    assign bus.out_target = r_main_tgt;
    assign bus.out_err    = r_main_err;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance.
module tb_imm_gen_stage;
    import riscv_pkg::*;

    logic clk;
    logic rst_n;
    logic flush32;
    logic flush64;
    int   n_cmp;
    int   n_bad;

    imm_gen_stage_if #(.XLEN(32)) if32 ();
    imm_gen_stage_if #(.XLEN(64)) if64 ();

    imm_gen_stage #(.XLEN(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush32),
        .bus   (if32)
    );

    imm_gen_stage #(.XLEN(64)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush64),
        .bus   (if64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put32(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] sel);
        if32.in_valid   = 1'b1;
        if32.in_instr   = instr;
        if32.in_pc      = pc;
        if32.in_imm_sel = sel;
    endtask

    task automatic put64(input logic [31:0] instr, input logic [63:0] pc, input logic [2:0] sel);
        if64.in_valid   = 1'b1;
        if64.in_instr   = instr;
        if64.in_pc      = pc;
        if64.in_imm_sel = sel;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        flush32 = 1'b0;
        flush64 = 1'b0;
        if32.in_valid = 1'b0; if32.in_instr = '0; if32.in_pc = '0;
        if32.in_imm_sel = '0; if32.out_ready = 1'b1;
        if64.in_valid = 1'b0; if64.in_instr = '0; if64.in_pc = '0;
        if64.in_imm_sel = '0; if64.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_in_ready",  64'(if32.in_ready),  64'd1);
        chk("rst_imm",       64'(if32.out_imm),   64'd0);
        chk("rst_target",    64'(if32.out_target), 64'd0);
        chk("rst_err",       64'(if32.out_err),   64'd0);
        rst_n = 1'b1;
        tick();

        // XLEN=32 formats, streaming back-to-back with out_ready high
        put32(32'hFFF00093, 32'h100, IMM_I);
        tick();
        chk("i_valid",  64'(if32.out_valid),  64'd1);
        chk("i_imm",    64'(if32.out_imm),    64'hFFFFFFFF);
        chk("i_target", 64'(if32.out_target), 64'h000000FF);
        chk("i_err",    64'(if32.out_err),    64'd0);
        put32(32'hFE000CE3, 32'h200, IMM_B);
        tick();
        chk("b_imm",    64'(if32.out_imm),    64'hFFFFFFF8);
        chk("b_target", 64'(if32.out_target), 64'h000001F8);
        put32(32'h0010006F, 32'h1000, IMM_J);
        tick();
        chk("j_imm",    64'(if32.out_imm),    64'h00000800);
        chk("j_target", 64'(if32.out_target), 64'h00001800);
        put32(32'h00112623, 32'h40, IMM_S);
        tick();
        chk("s_imm",    64'(if32.out_imm),    64'd12);
        chk("s_target", 64'(if32.out_target), 64'h4C);
        put32(32'hFFFF8073, 32'h0, IMM_Z);
        tick();
        chk("z_imm",    64'(if32.out_imm),    64'h1F);
        put32(32'h03F0D093, 32'h0, IMM_SH);
        tick();
        chk("sh32_imm", 64'(if32.out_imm),    64'h1F);
        put32(32'h12345678, 32'h300, IMM_ILL);
        tick();
        chk("ill32_imm", 64'(if32.out_imm),    64'd0);
        chk("ill32_err", 64'(if32.out_err),    64'd1);
        chk("ill32_tgt", 64'(if32.out_target), 64'h300);
        if32.in_valid = 1'b0;
        tick();
        chk("drain_valid", 64'(if32.out_valid), 64'd0);

        // XLEN=64 formats
        put64(32'h800000B7, 64'h10, IMM_U);
        tick();
        chk("u64_imm", if64.out_imm,    64'hFFFFFFFF80000000);
        chk("u64_tgt", if64.out_target, 64'hFFFFFFFF80000010);
        put64(32'h03F0D093, 64'h0, IMM_SH);
        tick();
        chk("sh64_imm", if64.out_imm, 64'h3F);
        put64(32'hFFF00093, 64'h100, IMM_I);
        tick();
        chk("i64_imm", if64.out_imm,    64'hFFFFFFFFFFFFFFFF);
        chk("i64_tgt", if64.out_target, 64'hFF);
        put64(32'hFFFFFFFF, 64'h500, IMM_ILL);
        tick();
        chk("ill64_imm", if64.out_imm,          64'd0);
        chk("ill64_err", 64'(if64.out_err),     64'd1);
        chk("ill64_tgt", if64.out_target,       64'h500);
        if64.in_valid = 1'b0;
        tick();

        // Backpressure: A, B, C with a 3-cycle stall
        if32.out_ready = 1'b0;
        put32(32'h00100093, 32'h0, IMM_I);
        tick();
        chk("bp_a_imm", 64'(if32.out_imm), 64'd1);
        chk("bp_rdy1",  64'(if32.in_ready), 64'd1);
        put32(32'h00200093, 32'h0, IMM_I);
        tick();
        chk("bp_hold_a", 64'(if32.out_imm), 64'd1);
        chk("bp_rdy_full", 64'(if32.in_ready), 64'd0);
        put32(32'h00300093, 32'h0, IMM_I);
        tick();
        chk("bp_hold_a2", 64'(if32.out_imm), 64'd1);
        chk("bp_c_stall", 64'(if32.in_ready), 64'd0);
        chk("bp_valid",   64'(if32.out_valid), 64'd1);
        if32.out_ready = 1'b1;
        tick();
        chk("bp_out_b",  64'(if32.out_imm), 64'd2);
        chk("bp_rdy_back", 64'(if32.in_ready), 64'd1);
        tick();
        chk("bp_out_c",  64'(if32.out_imm), 64'd3);
        chk("bp_c_valid", 64'(if32.out_valid), 64'd1);
        if32.in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(if32.out_valid), 64'd0);

        // Flush while FULL with an entry offered
        if32.out_ready = 1'b0;
        put32(32'h00100093, 32'h0, IMM_I);
        tick();
        put32(32'h00200093, 32'h0, IMM_I);
        tick();
        chk("fl_full", 64'(if32.in_ready), 64'd0);
        put32(32'h00300093, 32'h0, IMM_I);
        flush32 = 1'b1;
        tick();
        chk("fl_valid", 64'(if32.out_valid), 64'd0);
        chk("fl_ready", 64'(if32.in_ready),  64'd1);
        flush32 = 1'b0;
        if32.in_valid = 1'b0;
        if32.out_ready = 1'b1;
        tick();
        chk("fl_dropped", 64'(if32.out_valid), 64'd0);

        // Asynchronous reset mid-stream
        put32(32'hFFF00093, 32'h100, IMM_I);
        tick();
        chk("rs_loaded", 64'(if32.out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rs_valid",  64'(if32.out_valid),  64'd0);
        chk("rs_imm",    64'(if32.out_imm),    64'd0);
        chk("rs_target", 64'(if32.out_target), 64'd0);
        chk("rs_ready",  64'(if32.in_ready),   64'd1);
        if32.in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate-generation stage for the RISC-V core's decode path. It accepts an instruction, PC and format select over a valid/ready handshake, extracts and sign-extends the immediate to `XLEN`, and precomputes `pc + imm` as the branch/jump target. Results appear on a registered valid/ready output one cycle later. A 2-entry skid buffer sustains one transfer per cycle under backpressure, and a flush input supports redirects.

## Interface
- `XLEN`, default 32, is the datapath width. Legal values are 32 or 64; any other value is an elaboration error.
- `clk`  in  1  is the core clock.
- `rst_n`  in  1  is the reset: asynchronous, active-low.
- `flush`  in  1  is a synchronous kill. It drops all buffered entries and any input offered in the same cycle.
- `in_valid`  in  1  means an upstream entry is offered.
- `in_ready`  out  1  means the stage can accept an entry.
- `in_instr`  in  32  is the raw instruction word.
- `in_pc`  in  XLEN  is the instruction PC.
- `in_imm_sel`  in  3  is the format select. The encodings are:
  - 000 I
  - 001 S
  - 010 B
  - 011 U
  - 100 J
  - 101 Z (CSR zimm)
  - 110 SH (shift amount)
  - 111 illegal
- `out_valid`  out  1  means a result is presented.
- `out_ready`  in  1  means downstream accepts the result.
- `out_imm`  out  XLEN  is the extended immediate.
- `out_target`  out  XLEN  is `pc + imm`, modulo 2^XLEN.
- `out_err`  out  1  is set when the select was illegal.

## Operation
- **Immediate formats.** All are sign-extended from `instr[31]` to XLEN unless stated otherwise.
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`. For XLEN=64, bits above 31 replicate `instr[31]`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - Z: `instr[19:15]`, zero-extended.
  - SH: `instr[24:20]` zero-extended when XLEN=32, `instr[25:20]` zero-extended when XLEN=64.
  - 111: imm = 0 and err = 1. Target is still computed as `pc + 0`.
- **Target.** Computed for every format; downstream ignores it where it is meaningless.
- **Input transfer.** Occurs when `in_valid & in_ready & !flush`.
- **Output transfer.** Occurs when `out_valid & out_ready`.
- **Buffer entries.**
  - Main register: drives the outputs.
  - Skid register: holds one extra entry.
  - `in_ready = !skid_valid`. It is a pure register output with no combinational path from `out_ready`.
- **Buffer states.** Transitions are listed per state.
  - EMPTY:
    - Input → ONE.
  - ONE:
    - Input without output → FULL. The new entry goes to skid.
    - Input with output → ONE. The new entry replaces main.
    - Output only → EMPTY.
  - FULL:
    - Output → ONE. Skid moves to main.
    - Inputs are refused while in FULL.
- **Flush.** Next state is EMPTY. Any output transfer in the flush cycle still counts as completed, because downstream sampled it. Flush has priority over every simultaneous event.
- **Ordering.** Entries leave in acceptance order, with no loss or duplication.

## Timing
- **Latency:** 1 cycle from input transfer to `out_valid` when the stage was EMPTY or draining.
- **Throughput:** 1 entry per cycle while `out_ready` is held at 1.
- **Reset values:**
  - `out_valid` = 0
  - `in_ready` = 1 (skid empty)
  - `out_imm`, `out_target`, `out_err` = 0
  - State = EMPTY
- **Reset mid-operation:** reset asserted mid-operation clears both entries immediately, asynchronously. Entries in flight are lost.
- **Stable outputs:** `out_*` data holds stable while `out_valid & !out_ready`.
- **`in_ready` after stall:** returns to 1 in the cycle after the FULL→ONE transition.

## Structure
- **Shared package `riscv_pkg`:**
  - `IMM_I` … `IMM_ILL` select constants.
  - `XLEN` legality check.
- **Sub-module `imm_extract`:** combinational format decode and extension, parametrised by `XLEN`. It is instantiated once, ahead of the main/skid registers.
- **Adder placement:** the target adder sits before the registers, so both entries store the finished results.

## Test plan
- **I-type, XLEN=32.** Drive instr 0xFFF00093, sel I, pc 0x100. The next cycle must show imm 0xFFFFFFFF, target 0x000000FF, err 0.
- **B-type.** Drive instr 0xFE000CE3, sel B, pc 0x200. Required: imm 0xFFFFFFF8, target 0x000001F8.
- **J-type.** Drive instr 0x0010006F, sel J, pc 0x1000. Required: imm 0x00000800, target 0x00001800.
- **XLEN=64.**
  - U-type: instr 0x800000B7 must give imm 0xFFFFFFFF80000000.
  - SH: instr 0x03F0D093 must give imm 0x3F.
  - Sel 111 must give imm 0 and err 1.
- **Backpressure.**
  - Stimulus: stream A, B, C with `out_ready` = 0 for 3 cycles.
  - While stalled: A is held on the outputs, B is skidded, `in_ready` is 0, and C is stalled.
  - After release: A, B, C leave on consecutive cycles.
- **Flush and reset.**
  - Flush while FULL, with `in_valid` = 1: the next cycle must show `out_valid` 0 and `in_ready` 1, and the offered entry is dropped.
  - `rst_n` pulsed low mid-stream: all outputs are 0 immediately.
